// File: rtl/gate_unit_pipe.sv
// -----------------------------------------------------------------------------
// gate_unit_pipe
//
// Registered bitwise gate unit with valid/ready handshakes on both sides.
// One of seven bitwise ops (NOT/AND/NAND/OR/NOR/XOR/XNOR) is applied to
// WIDTH-bit operands. The result and its status flags appear one cycle after
// the input transfer. In accumulate mode the second operand is an internal
// accumulator. Each legal op writes its result back into the accumulator.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 1)
//   CNT_W   width of the accepted-transfer counter (wraps silently)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands/op valid
//   in_ready   out  unit can accept (transfer on in_valid && in_ready)
//   op         in   0 NOT a, 1 AND, 2 NAND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 illegal
//   acc_mode   in   1: second operand is the accumulator instead of b
//   a, b       in   operands
//   out_valid  out  result registers hold an unconsumed result
//   out_ready  in   consumer accepts (transfer on out_valid && out_ready)
//   result     out  registered op result
//   zero       out  result == 0
//   parity     out  XOR-reduction of result
//   op_err     out  result came from an illegal op
//   op_count   out  number of accepted input transfers
// -----------------------------------------------------------------------------
module gate_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             op_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    // Bitwise gate evaluation. NOT ignores the second operand. The illegal
    // code yields all zeros so the held result is well defined.
    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_x,
        input logic [WIDTH-1:0] f_y
    );
        logic [WIDTH-1:0] r;
        case (f_op)
            OP_NOT:  r = ~f_x;
            OP_AND:  r = f_x & f_y;
            OP_NAND: r = ~(f_x & f_y);
            OP_OR:   r = f_x | f_y;
            OP_NOR:  r = ~(f_x | f_y);
            OP_XOR:  r = f_x ^ f_y;
            OP_XNOR: r = ~(f_x ^ f_y);
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Even-parity bit of a result word.
    function automatic logic parity_of(input logic [WIDTH-1:0] f_v);
        return ^f_v;
    endfunction

    // Checks whether an op code names one of the seven gates.
    function automatic logic is_legal(input logic [2:0] f_op);
        logic r;
        case (f_op)
            OP_NOT, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR: r = 1'b1;
            default:                                                 r = 1'b0;
        endcase
        return r;
    endfunction

    // State registers and their next-state values
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             zero_q,      zero_d;
    logic             parity_q,    parity_d;
    logic             op_err_q,    op_err_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;
    logic [WIDTH-1:0] acc_q,       acc_d;

    logic             accept_s;
    logic [WIDTH-1:0] opb_s;
    logic [WIDTH-1:0] calc_s;
    logic             legal_s;

    // The output slot frees up in the same cycle it is popped, so a new
    // operand can be taken every cycle under full throughput.
    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Datapath: operand select and gate evaluation
    always_comb begin
        opb_s   = acc_mode ? acc_q : b;
        calc_s  = gate_eval(op, a, opb_s);
        legal_s = is_legal(op);
    end

    // Next-state logic. Registers load only on an accepted transfer, so inputs
    // presented without in_valid never reach any state.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        op_err_d    = op_err_q;
        op_count_d  = op_count_q;
        acc_d       = acc_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            result_d    = calc_s;
            zero_d      = (calc_s == {WIDTH{1'b0}});
            parity_d    = parity_of(calc_s);
            op_err_d    = !legal_s;
            op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (legal_s) begin
                acc_d = calc_s;
            end else begin
                acc_d = acc_q;
            end
        end else if (out_valid_q && out_ready) begin
            // Popped with nothing arriving: the slot empties, data is held
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register with synchronous reset that discards any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            op_err_q    <= 1'b0;
            op_count_q  <= {CNT_W{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            op_err_q    <= op_err_d;
            op_count_q  <= op_count_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign op_err    = op_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
module tb_gate_unit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        acc_mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic        zero;
    logic        parity;
    logic        op_err;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state
    logic        m_valid;
    logic [7:0]  m_result;
    logic        m_err;
    logic [7:0]  m_acc;
    logic [15:0] m_count;

    gate_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_mode(acc_mode), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .parity(parity),
        .op_err(op_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       err;
    } vec_t;

    function automatic logic [7:0] ref_gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & y;
            3'd2:    return ~(x & y);
            3'd3:    return x | y;
            3'd4:    return ~(x | y);
            3'd5:    return x ^ y;
            3'd6:    return ~(x ^ y);
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setin(input logic v, input logic [2:0] o, input logic am,
                         input logic [7:0] x, input logic [7:0] y,
                         input logic ordy, input logic r);
        in_valid = v; op = o; acc_mode = am; a = x; b = y; out_ready = ordy; rst = r;
    endtask

    // One clock: check in_ready, advance the model by the spec rules, check outputs
    task automatic step(input bit full);
        logic acc_ok;
        logic [7:0] r;
        #1;
        if (full) check("in_ready", in_ready, !m_valid || out_ready);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_result = 0; m_err = 0; m_acc = 0; m_count = 0;
        end else begin
            acc_ok = in_valid && (!m_valid || out_ready);
            if (acc_ok) begin
                r = ref_gate(op, a, acc_mode ? m_acc : b);
                m_result = r;
                m_err    = (op == 3'd7);
                if (op != 3'd7) m_acc = r;
                m_count  = m_count + 16'd1;
                m_valid  = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        if (full) begin
            check("out_valid", out_valid, m_valid);
            check("result", result, m_result);
            check("zero", zero, m_result == 8'h00);
            check("parity", parity, ^m_result);
            check("op_err", op_err, m_err);
            check("op_count", op_count, m_count);
        end
    endtask

    task automatic do_reset();
        setin(0, 3'd0, 0, 8'h00, 8'h00, 1, 1);
        step(1);
        rst = 0;
    endtask

    vec_t tbl[8];

    initial begin
        m_valid = 0; m_result = 0; m_err = 0; m_acc = 0; m_count = 0;
        setin(0, 3'd0, 0, 8'h00, 8'h00, 0, 1);

        tbl[0] = '{3'd0, 8'h3C, 8'hF0, 8'hC3, 1'b0};
        tbl[1] = '{3'd1, 8'h3C, 8'hF0, 8'h30, 1'b0};
        tbl[2] = '{3'd2, 8'h3C, 8'hF0, 8'hCF, 1'b0};
        tbl[3] = '{3'd3, 8'h3C, 8'hF0, 8'hFC, 1'b0};
        tbl[4] = '{3'd4, 8'h3C, 8'hF0, 8'h03, 1'b0};
        tbl[5] = '{3'd5, 8'h3C, 8'hF0, 8'hCC, 1'b0};
        tbl[6] = '{3'd6, 8'h3C, 8'hF0, 8'h33, 1'b0};
        tbl[7] = '{3'd7, 8'h3C, 8'hF0, 8'h00, 1'b1};

        // Reset state
        do_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_zero", zero, 1'b1);
        check("rst_count", op_count, 16'h0000);

        // Test 1: single AND
        setin(1, 3'd1, 0, 8'hA5, 8'h0F, 1, 0);
        step(1);
        check("t1_result", result, 8'h05);
        check("t1_valid", out_valid, 1'b1);
        check("t1_zero", zero, 1'b0);
        check("t1_parity", parity, 1'b0);
        check("t1_count", op_count, 16'h0001);

        // Test 2: back-to-back NOT, XOR, XNOR at full throughput
        setin(1, 3'd0, 0, 8'hA5, 8'h0F, 1, 0);
        #1 check("t2_ready0", in_ready, 1'b1);
        step(1); check("t2_not", result, 8'h5A);
        op = 3'd5;
        #1 check("t2_ready1", in_ready, 1'b1);
        step(1); check("t2_xor", result, 8'hAA);
        op = 3'd6;
        #1 check("t2_ready2", in_ready, 1'b1);
        step(1); check("t2_xnor", result, 8'h55);

        // Test 3: backpressure hold for five cycles, then drain
        setin(0, 3'd1, 0, 8'hFF, 8'hFF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_ready", in_ready, 1'b0);
            in_valid = 1;  // offered but must not be taken
            step(1);
            check("t3_hold", result, 8'h55);
            check("t3_count", op_count, 16'h0004);
        end
        setin(0, 3'd1, 0, 8'hFF, 8'hFF, 1, 0);
        step(1);
        check("t3_drain", out_valid, 1'b0);

        // Table-driven single transfers, b-mode
        for (int i = 0; i < 8; i++) begin
            setin(1, tbl[i].op, 0, tbl[i].a, tbl[i].b, 1, 0);
            step(1);
            check($sformatf("tbl%0d_res", i), result, tbl[i].res);
            check($sformatf("tbl%0d_err", i), op_err, tbl[i].err);
            check($sformatf("tbl%0d_zero", i), zero, tbl[i].res == 8'h00);
        end

        // Test 4: accumulate chain
        do_reset();
        setin(1, 3'd3, 1, 8'h01, 8'hAA, 1, 0); step(1); check("t4_or1", result, 8'h01);
        a = 8'h02;                              step(1); check("t4_or2", result, 8'h03);
        op = 3'd2; a = 8'hFF;                   step(1); check("t4_nand", result, 8'hFC);

        // Test 5: illegal op leaves accumulator alone
        setin(1, 3'd7, 0, 8'hFF, 8'hFF, 1, 0); step(1);
        check("t5_res", result, 8'h00);
        check("t5_err", op_err, 1'b1);
        check("t5_zero", zero, 1'b1);
        setin(1, 3'd3, 1, 8'h00, 8'h00, 1, 0); step(1);
        check("t5_acc", result, 8'hFC);
        check("t5_err_clr", op_err, 1'b0);

        // Test 6: reset while a result is stalled
        setin(1, 3'd0, 0, 8'h0F, 8'h00, 0, 0); step(1);
        setin(0, 3'd0, 0, 8'h00, 8'h00, 0, 1); step(1);
        rst = 0;
        check("t6_valid", out_valid, 1'b0);
        check("t6_count", op_count, 16'h0000);
        #1 check("t6_ready", in_ready, 1'b1);
        setin(1, 3'd3, 1, 8'h00, 8'h55, 1, 0); step(1);
        check("t6_acc", result, 8'h00);

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            setin($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom),
                  8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) == 0);
            step(1);
        end

        // Counter wrap
        do_reset();
        setin(1, 3'd1, 0, 8'hFF, 8'h0F, 1, 0);
        for (int i = 0; i < 65535; i++) step(0);
        #1 check("wrap_ffff", op_count, 16'hFFFF);
        step(1);
        check("wrap_0000", op_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
